// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - fetch request/response, redirect and decode handoff bundle
interface ifetch_queue_if;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc4;
   logic        id_ready;

   modport master (
      output mem_req_valid, mem_req_addr, id_valid, id_inst, id_pc4,
      input  mem_req_ready, mem_resp_valid, mem_resp_data,
      input  redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, id_valid, id_inst, id_pc4,
      output mem_req_ready, mem_resp_valid, mem_resp_data,
      output redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction prefetch queue with redirect flush
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic           clk,
   input  logic           rst,
   ifetch_queue_if.master bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef logic [CW-1:0] cnt_t;
   typedef logic [AW-1:0] ptr_t;

   localparam cnt_t        DEPTH_C = cnt_t'(DEPTH);
   localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

   logic [31:0] r_fetch_pc;
   logic [31:0] r_head_pc;
   cnt_t        r_count;
   cnt_t        r_inflight;
   cnt_t        r_drop_cnt;
   ptr_t        r_rd;
   ptr_t        r_wr;
   logic [31:0] r_buf [DEPTH];

   logic [CW:0] w_used;
   logic        w_req_valid;
   logic        w_accept;
   logic        w_resp;
   logic        w_drop;
   logic        w_push;
   logic        w_pop;
   logic        w_redirect;
   cnt_t        w_inflight_less_resp;

   // Credits cover both buffered and outstanding words, so a push never finds the buffer full.
   assign w_used      = {1'b0, r_count} + {1'b0, r_inflight};
   assign w_redirect  = bus.redirect_valid;
   assign w_req_valid = !rst && !w_redirect && (w_used < CREDITS);
   assign w_accept    = w_req_valid && bus.mem_req_ready;
   assign w_resp      = bus.mem_resp_valid;
   assign w_drop      = w_resp && (r_drop_cnt != '0);
   assign w_push      = !rst && w_resp && !w_drop && !w_redirect;
   assign w_pop       = (r_count != '0) && bus.id_ready && !w_redirect;

   assign w_inflight_less_resp = r_inflight - cnt_t'(w_resp);

   assign bus.mem_req_valid = w_req_valid;
   assign bus.mem_req_addr  = r_fetch_pc;
   assign bus.id_valid      = !rst && (r_count != '0);
   assign bus.id_inst       = rst ? 32'h0 : r_buf[r_rd];
   assign bus.id_pc4        = r_head_pc + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_head_pc  <= RESET_PC;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_rd       <= '0;
         r_wr       <= '0;
      end else if (w_redirect) begin
         // Everything still outstanding belongs to the old path and must be discarded on return.
         r_fetch_pc <= bus.redirect_pc;
         r_head_pc  <= bus.redirect_pc;
         r_count    <= '0;
         r_rd       <= '0;
         r_wr       <= '0;
         r_inflight <= w_inflight_less_resp;
         r_drop_cnt <= w_inflight_less_resp;
      end else begin
         if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         r_inflight <= r_inflight + cnt_t'(w_accept) - cnt_t'(w_resp);
         if (w_drop) begin
            r_drop_cnt <= r_drop_cnt - cnt_t'(1);
         end
         if (w_push) begin
            r_wr <= r_wr + ptr_t'(1);
         end
         if (w_pop) begin
            r_rd      <= r_rd + ptr_t'(1);
            r_head_pc <= r_head_pc + 32'd4;
         end
         r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf[r_wr] <= bus.mem_resp_data;
      end
   end

   a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
      bus.mem_resp_valid |-> (r_inflight != '0))
      else $fatal(1, "ifetch_queue: response with nothing outstanding");

   a_push_not_full: assert property (@(posedge clk) disable iff (rst)
      w_push |-> (r_count != DEPTH_C))
      else $fatal(1, "ifetch_queue: push into full buffer");
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized self-checking bench for ifetch_queue
module tb_ifetch_queue;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam int          DEPTH    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifetch_queue_if bus ();

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          drop;
   } pend_t;

   pend_t       pend[$];
   int          m_buf;
   logic [31:0] exp_pop_pc;
   logic [31:0] exp_req_pc;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          n_checks = 0;
   int          n_pass = 0;

   logic        drv_redirect;
   logic [31:0] drv_rpc;
   logic        drv_ready;
   logic        drv_id_ready;
   logic        drv_resp_en;

   logic        o_req_valid, o_exp_req_valid, o_req, o_idv, o_exp_idv, o_pop, o_resp;
   logic [31:0] o_req_addr, o_exp_req_addr, o_pop_pc4, o_pop_inst, o_exp_pop_pc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic drive_idle();
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = 32'h0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.id_ready       = 1'b0;
   endtask

   task automatic model_clear();
      pend.delete();
      m_buf        = 0;
      exp_pop_pc   = RESET_PC;
      exp_req_pc   = RESET_PC;
      drv_redirect = 1'b0;
      drv_rpc      = 32'h0;
      drv_ready    = 1'b1;
      drv_id_ready = 1'b1;
      drv_resp_en  = 1'b1;
      lat_min      = 1;
      lat_max      = 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: drive at negedge, sample shortly after, then advance the reference model.
   task automatic step();
      int    c;
      int    l;
      pend_t e;
      @(negedge clk);
      bus.redirect_valid = drv_redirect;
      bus.redirect_pc    = drv_rpc;
      bus.mem_req_ready  = drv_ready;
      bus.id_ready       = drv_id_ready;
      if (drv_resp_en && pend.size() > 0 && pend[0].due <= cyc) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = memf(pend[0].addr);
      end else begin
         bus.mem_resp_valid = 1'b0;
         bus.mem_resp_data  = 32'h0;
      end
      #1;
      o_req_valid     = bus.mem_req_valid;
      o_req_addr      = bus.mem_req_addr;
      o_req           = o_req_valid && drv_ready;
      o_exp_req_valid = !drv_redirect && ((m_buf + pend.size()) < DEPTH);
      o_exp_req_addr  = exp_req_pc;
      o_idv           = bus.id_valid;
      o_exp_idv       = (m_buf > 0);
      o_pop           = bus.id_valid && drv_id_ready && !drv_redirect;
      o_pop_pc4       = bus.id_pc4;
      o_pop_inst      = bus.id_inst;
      o_exp_pop_pc    = exp_pop_pc;
      o_resp          = bus.mem_resp_valid;
      @(posedge clk);
      c   = cyc;
      cyc = cyc + 1;
      if (drv_redirect) begin
         if (o_resp) e = pend.pop_front();
         foreach (pend[k]) pend[k].drop = 1'b1;
         m_buf      = 0;
         exp_pop_pc = drv_rpc;
         exp_req_pc = drv_rpc;
      end else begin
         if (o_resp) begin
            e = pend.pop_front();
            if (!e.drop) m_buf++;
         end
         if (o_pop) begin
            m_buf--;
            exp_pop_pc = exp_pop_pc + 32'd4;
         end
         if (o_req) begin
            l = $urandom_range(lat_max, lat_min);
            pend.push_back('{addr: exp_req_pc, due: c + l, drop: 1'b0});
            exp_req_pc = exp_req_pc + 32'd4;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      model_clear();
      #7;
      n_checks++;
      if (bus.mem_req_valid !== 1'b0 || bus.id_valid !== 1'b0)
         $display("FAIL reset_valids: req_valid=%b id_valid=%b want 0 0", bus.mem_req_valid, bus.id_valid);
      else n_pass++;
      n_checks++;
      if (bus.id_inst !== 32'h0 || bus.id_pc4 !== RESET_PC + 32'd4)
         $display("FAIL reset_id: inst=%h pc4=%h want %h %h", bus.id_inst, bus.id_pc4, 32'h0, RESET_PC + 32'd4);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      step();
      n_checks++;
      if (o_req_valid !== 1'b1 || o_req_addr !== RESET_PC)
         $display("FAIL reset_first_req: valid=%b addr=%h want 1 %h", o_req_valid, o_req_addr, RESET_PC);
      else n_pass++;
   endtask

   task automatic test_stream();
      int bubbles = 0;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         step();
         if (o_req) begin
            n_checks++;
            if (o_req_addr !== o_exp_req_addr)
               $display("FAIL stream_addr: got %h want %h", o_req_addr, o_exp_req_addr);
            else n_pass++;
         end
         if (o_pop) begin
            n_checks++;
            if (o_pop_pc4 !== o_exp_pop_pc + 32'd4 || o_pop_inst !== memf(o_exp_pop_pc))
               $display("FAIL stream_pop: pc4=%h inst=%h want %h %h", o_pop_pc4, o_pop_inst,
                        o_exp_pop_pc + 32'd4, memf(o_exp_pop_pc));
            else n_pass++;
         end
         if (i >= 3 && !o_idv) bubbles++;
      end
      n_checks++;
      if (bubbles !== 0) $display("FAIL stream_bubbles: got %0d want 0", bubbles);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] seen[$];
      bit          first = 1'b1;
      do_reset();
      drv_id_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (o_req) seen.push_back(o_req_addr);
      end
      n_checks++;
      if (seen.size() !== 4) $display("FAIL bp_req_count: got %0d want 4", seen.size());
      else n_pass++;
      foreach (seen[k]) begin
         n_checks++;
         if (seen[k] !== RESET_PC + 32'(4 * k))
            $display("FAIL bp_addr: got %h want %h", seen[k], RESET_PC + 32'(4 * k));
         else n_pass++;
      end
      n_checks++;
      if (o_req_valid !== 1'b0) $display("FAIL bp_stalled: req_valid=%b want 0", o_req_valid);
      else n_pass++;
      drv_id_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (o_req && first) begin
            first = 1'b0;
            n_checks++;
            if (o_req_addr !== RESET_PC + 32'h10)
               $display("FAIL bp_resume: got %h want %h", o_req_addr, RESET_PC + 32'h10);
            else n_pass++;
         end
         if (o_pop) begin
            n_checks++;
            if (o_pop_pc4 !== o_exp_pop_pc + 32'd4 || o_pop_inst !== memf(o_exp_pop_pc))
               $display("FAIL bp_pop: pc4=%h inst=%h want %h %h", o_pop_pc4, o_pop_inst,
                        o_exp_pop_pc + 32'd4, memf(o_exp_pop_pc));
            else n_pass++;
         end
      end
   endtask

   task automatic test_redirect();
      int first_idv = -1;
      bit first_pop = 1'b1;
      do_reset();
      lat_min = 5;
      lat_max = 5;
      for (int i = 0; i < 25; i++) begin
         drv_redirect = (i == 3);
         drv_rpc      = 32'h40;
         step();
         if (i > 3 && o_idv && first_idv < 0) first_idv = i;
         if (o_pop) begin
            n_checks++;
            if (o_pop_pc4 !== o_exp_pop_pc + 32'd4 || o_pop_inst !== memf(o_exp_pop_pc))
               $display("FAIL redir_pop: pc4=%h inst=%h want %h %h", o_pop_pc4, o_pop_inst,
                        o_exp_pop_pc + 32'd4, memf(o_exp_pop_pc));
            else n_pass++;
            if (first_pop) begin
               first_pop = 1'b0;
               n_checks++;
               if (o_pop_pc4 !== 32'h44) $display("FAIL redir_first_pc4: got %h want 44", o_pop_pc4);
               else n_pass++;
            end
         end
      end
      n_checks++;
      if (first_idv !== 10) $display("FAIL redir_first_valid_cycle: got %0d want 10", first_idv);
      else n_pass++;
      drv_redirect = 1'b0;
   endtask

   task automatic test_redirect_collide();
      bit first_pop = 1'b1;
      do_reset();
      lat_min = 2;
      lat_max = 2;
      for (int i = 0; i < 26; i++) begin
         drv_redirect = (i == 10);
         drv_rpc      = 32'h80;
         step();
         if (i == 10) begin
            n_checks++;
            if (o_resp !== 1'b1 || o_idv !== 1'b1)
               $display("FAIL collide_setup: resp=%b id_valid=%b want 1 1", o_resp, o_idv);
            else n_pass++;
         end
         if (o_pop) begin
            n_checks++;
            if (o_pop_pc4 !== o_exp_pop_pc + 32'd4 || o_pop_inst !== memf(o_exp_pop_pc))
               $display("FAIL collide_pop: pc4=%h inst=%h want %h %h", o_pop_pc4, o_pop_inst,
                        o_exp_pop_pc + 32'd4, memf(o_exp_pop_pc));
            else n_pass++;
            if (i > 10 && first_pop) begin
               first_pop = 1'b0;
               n_checks++;
               if (o_pop_inst !== memf(32'h80)) $display("FAIL collide_first: got %h want %h", o_pop_inst, memf(32'h80));
               else n_pass++;
            end
         end
      end
      drv_redirect = 1'b0;
   endtask

   task automatic test_req_stall();
      logic [31:0] held;
      do_reset();
      repeat (4) step();
      drv_ready = 1'b0;
      held      = exp_req_pc;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (o_req_valid !== 1'b1 || o_req_addr !== held)
            $display("FAIL stall_hold: valid=%b addr=%h want 1 %h", o_req_valid, o_req_addr, held);
         else n_pass++;
      end
      drv_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (o_req) begin
            n_checks++;
            if (o_req_addr !== o_exp_req_addr) $display("FAIL stall_resume: got %h want %h", o_req_addr, o_exp_req_addr);
            else n_pass++;
         end
         if (o_pop) begin
            n_checks++;
            if (o_pop_pc4 !== o_exp_pop_pc + 32'd4 || o_pop_inst !== memf(o_exp_pop_pc))
               $display("FAIL stall_pop: pc4=%h inst=%h want %h %h", o_pop_pc4, o_pop_inst,
                        o_exp_pop_pc + 32'd4, memf(o_exp_pop_pc));
            else n_pass++;
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      lat_min      = 2;
      lat_max      = 2;
      drv_id_ready = 1'b0;
      repeat (4) step();
      @(negedge clk);
      #2;
      n_checks++;
      if (bus.id_valid !== 1'b1 || m_buf !== 2 || pend.size() !== 2)
         $display("FAIL arst_setup: id_valid=%b buf=%0d out=%0d want 1 2 2", bus.id_valid, m_buf, pend.size());
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.mem_req_valid !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 ||
          bus.id_pc4 !== RESET_PC + 32'd4)
         $display("FAIL arst_outputs: req=%b idv=%b inst=%h pc4=%h want 0 0 0 %h", bus.mem_req_valid,
                  bus.id_valid, bus.id_inst, bus.id_pc4, RESET_PC + 32'd4);
      else n_pass++;
      drive_idle();
      model_clear();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step();
      n_checks++;
      if (o_req !== 1'b1 || o_req_addr !== RESET_PC)
         $display("FAIL arst_restart: req=%b addr=%h want 1 %h", o_req, o_req_addr, RESET_PC);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         step();
         if (o_pop) begin
            n_checks++;
            if (o_pop_pc4 !== o_exp_pop_pc + 32'd4 || o_pop_inst !== memf(o_exp_pop_pc))
               $display("FAIL arst_pop: pc4=%h inst=%h want %h %h", o_pop_pc4, o_pop_inst,
                        o_exp_pop_pc + 32'd4, memf(o_exp_pop_pc));
            else n_pass++;
         end
      end
   endtask

   task automatic test_wrap();
      bit saw_wrap = 1'b0;
      do_reset();
      drv_redirect = 1'b1;
      drv_rpc      = 32'hFFFF_FFF8;
      step();
      drv_redirect = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (o_pop) begin
            n_checks++;
            if (o_pop_pc4 !== o_exp_pop_pc + 32'd4 || o_pop_inst !== memf(o_exp_pop_pc))
               $display("FAIL wrap_pop: pc4=%h inst=%h want %h %h", o_pop_pc4, o_pop_inst,
                        o_exp_pop_pc + 32'd4, memf(o_exp_pop_pc));
            else n_pass++;
            if (o_exp_pop_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
         end
      end
      n_checks++;
      if (saw_wrap !== 1'b1) $display("FAIL wrap_reached: got %b want 1", saw_wrap);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      lat_min = 1;
      lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         drv_ready    = ($urandom % 4) != 0;
         drv_id_ready = ($urandom % 3) != 0;
         drv_resp_en  = ($urandom % 4) != 0;
         drv_redirect = ($urandom % 40) == 0;
         drv_rpc      = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
         step();
         n_checks++;
         if (o_req_valid !== o_exp_req_valid)
            $display("FAIL rnd_req_valid: got %b want %b at %0d", o_req_valid, o_exp_req_valid, i);
         else n_pass++;
         if (o_req) begin
            n_checks++;
            if (o_req_addr !== o_exp_req_addr) $display("FAIL rnd_addr: got %h want %h", o_req_addr, o_exp_req_addr);
            else n_pass++;
         end
         n_checks++;
         if (o_idv !== o_exp_idv) $display("FAIL rnd_id_valid: got %b want %b at %0d", o_idv, o_exp_idv, i);
         else n_pass++;
         if (o_pop) begin
            n_checks++;
            if (o_pop_pc4 !== o_exp_pop_pc + 32'd4 || o_pop_inst !== memf(o_exp_pop_pc))
               $display("FAIL rnd_pop: pc4=%h inst=%h want %h %h", o_pop_pc4, o_pop_inst,
                        o_exp_pop_pc + 32'd4, memf(o_exp_pop_pc));
            else n_pass++;
         end
      end
      drv_redirect = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_collide();
      test_req_stall();
      test_async_reset();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
